// File: rtl/bt_pkg.sv
// bt_pkg: shared receiver FSM encoding, default command bytes and baud-divider helpers.
package bt_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } rx_state_e;

    localparam logic [7:0] JUMP_CHAR_DEF     = 8'h4A;
    localparam logic [7:0] JUMP_CHAR_ALT_DEF = 8'h6A;

    function automatic int baud_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    function automatic int baud_half(input int clk_hz, input int baud);
        return baud_div(clk_hz, baud) / 2;
    endfunction

endpackage

// File: rtl/bt_uart_rx.sv
// bt_uart_rx: 8N1 UART receiver with 2-FF input synchroniser and framing check.
// byte_done/byte_val expose the stop-sample cycle so the top can register its decode alongside rx_valid.
module bt_uart_rx
    import bt_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 9600
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       byte_done,
    output logic [7:0] byte_val
);
    localparam int DIV  = baud_div(CLK_HZ, BAUD);
    localparam int HALF = baud_half(CLK_HZ, BAUD);
    localparam int CW   = DIV > 1 ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

    logic [1:0]    sync_q;
    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          rx_s;

    assign rx_s = sync_q[1];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                    state_d   = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == DIV_M1) begin
                    cnt_d     = '0;
                    shreg_d   = {rx_s, shreg_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == DIV_M1) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        rx_data_d  = shreg_q;
                        rx_valid_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q      <= 2'b11;
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            shreg_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], rx};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign byte_done = rx_valid_d;
    assign byte_val  = shreg_q;

endmodule

// File: rtl/bt_jump_rx.sv
// bt_jump_rx: Bluetooth UART command receiver producing a one-cycle jump_btn pulse for the game core.
// Define BT_JUMP_COOLDOWN_EN to suppress repeat jumps for COOLDOWN_CYC cycles after each pulse.
module bt_jump_rx
    import bt_pkg::*;
#(
    parameter int         CLK_HZ        = 50_000_000,
    parameter int         BAUD          = 9600,
    parameter logic [7:0] JUMP_CHAR     = JUMP_CHAR_DEF,
    parameter logic [7:0] JUMP_CHAR_ALT = JUMP_CHAR_ALT_DEF,
    parameter int         COOLDOWN_CYC  = 2_500_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    input  logic       game_alive,
    output logic       jump_btn,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic [7:0] jump_cnt
);
    logic       byte_done;
    logic [7:0] byte_val;
    logic       cool_ok;
    logic       jump_btn_q, jump_btn_d;
    logic [7:0] jump_cnt_q, jump_cnt_d;

    bt_uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_rx (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .byte_done (byte_done),
        .byte_val  (byte_val)
    );

    always_comb begin
        jump_btn_d = byte_done && game_alive && cool_ok &&
                     (byte_val == JUMP_CHAR || byte_val == JUMP_CHAR_ALT);
        jump_cnt_d = jump_cnt_q + {7'd0, jump_btn_d};
    end

`ifdef BT_JUMP_COOLDOWN_EN
    localparam int CCW = $clog2(COOLDOWN_CYC + 1);
    logic [CCW-1:0] cool_q, cool_d;

    assign cool_ok = cool_q == '0;

    always_comb cool_d = jump_btn_d ? CCW'(COOLDOWN_CYC - 1) : (cool_ok ? cool_q : cool_q - 1'b1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cool_q <= '0;
        else          cool_q <= cool_d;
    end
`else
    // No cooldown window: every qualifying byte may pulse.
    assign cool_ok = COOLDOWN_CYC >= 0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            jump_btn_q <= 1'b0;
            jump_cnt_q <= 8'h00;
        end else begin
            jump_btn_q <= jump_btn_d;
            jump_cnt_q <= jump_cnt_d;
        end
    end

    assign jump_btn = jump_btn_q;
    assign jump_cnt = jump_cnt_q;

endmodule

// File: tb/tb_bt_jump_rx.sv
// tb_bt_jump_rx: randomized frame stimulus for bt_jump_rx checked against a frame-level reference model.
module tb_bt_jump_rx;
    localparam int DIV      = 10;
    localparam int LATENCY  = 98;
    localparam int COOLDOWN = 50;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx = 1'b1;
    logic       game_alive = 1'b0;
    logic       jump_btn, rx_valid, frame_err;
    logic [7:0] rx_data, jump_cnt;

    int n_chk = 0, n_fail = 0;
    int cyc = 0, n_valid = 0, n_ferr = 0, n_jump = 0, n_orphan = 0, n_wide = 0, last_jump_cyc = 0;
    logic prev_jump = 1'b0;

    int         exp_cnt = 0;
    logic [7:0] exp_data = 8'h00;
`ifdef BT_JUMP_COOLDOWN_EN
    int exp_last_pulse = -100000;
`endif

    bt_jump_rx #(
        .CLK_HZ       (1_000_000),
        .BAUD         (100_000),
        .COOLDOWN_CYC (COOLDOWN)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx         (rx),
        .game_alive (game_alive),
        .jump_btn   (jump_btn),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .jump_cnt   (jump_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        n_valid   <= n_valid + int'(rx_valid);
        n_ferr    <= n_ferr + int'(frame_err);
        n_jump    <= n_jump + int'(jump_btn);
        n_orphan  <= n_orphan + int'(jump_btn && !rx_valid);
        n_wide    <= n_wide + int'(jump_btn && prev_jump);
        prev_jump <= jump_btn;
        if (jump_btn) last_jump_cyc <= cyc;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic sb, input int tail);
        logic [9:0] f;
        f = {sb, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            tick(DIV);
        end
        tick(tail);
        rx = 1'b1;
    endtask

    // kind: 0 good frame, 1 stop bit low then line held low, 2 short start glitch
    task automatic run_frame(input logic [7:0] b, input logic alive, input int kind, input int gap);
        int v0, f0, j0, t0;
        bit jmp;
        v0 = n_valid;
        f0 = n_ferr;
        j0 = n_jump;
        t0 = cyc;
        game_alive = alive;
        jmp = kind == 0 && alive && (b == 8'h4A || b == 8'h6A);
`ifdef BT_JUMP_COOLDOWN_EN
        if (jmp && t0 + LATENCY - exp_last_pulse < COOLDOWN) jmp = 1'b0;
        if (jmp) exp_last_pulse = t0 + LATENCY;
`endif
        if (kind == 2) begin
            rx = 1'b0;
            tick(3);
            rx = 1'b1;
            tick(15);
        end else begin
            send_frame(b, kind == 0, kind == 1 ? 30 : 0);
        end
        if (kind == 0) exp_data = b;
        if (jmp) exp_cnt = (exp_cnt + 1) % 256;
        chk("rx_valid_count", 32'(n_valid - v0), 32'(kind == 0));
        chk("frame_err_count", 32'(n_ferr - f0), 32'(kind == 1));
        chk("jump_pulse_count", 32'(n_jump - j0), 32'(jmp));
        chk("rx_data", 32'(rx_data), 32'(exp_data));
        chk("jump_cnt", 32'(jump_cnt), 32'(exp_cnt));
        if (jmp) chk("jump_latency", 32'(last_jump_cyc - t0), 32'(LATENCY));
        tick(kind == 1 && gap < 5 ? 5 : gap);
    endtask

    task automatic chk_reset_outputs();
        chk("reset_jump_btn", 32'(jump_btn), 32'd0);
        chk("reset_rx_valid", 32'(rx_valid), 32'd0);
        chk("reset_frame_err", 32'(frame_err), 32'd0);
        chk("reset_rx_data", 32'(rx_data), 32'd0);
        chk("reset_jump_cnt", 32'(jump_cnt), 32'd0);
    endtask

    initial begin
        logic [7:0] b;
        int r, kind;
        tick(3);
        chk_reset_outputs();
        reset_n = 1'b1;
        tick(5);

        run_frame(8'h4A, 1'b1, 0, 5);
        run_frame(8'h6A, 1'b1, 0, 0);
        run_frame(8'h41, 1'b1, 0, 5);
        run_frame(8'h4A, 1'b0, 0, 5);
        run_frame(8'h00, 1'b1, 2, 0);
        run_frame(8'h4A, 1'b1, 1, 5);
        run_frame(8'h4A, 1'b1, 0, 5);

        for (int i = 0; i < 40; i++) begin
            b = ($urandom_range(0, 9) < 4) ? ($urandom_range(0, 1) != 0 ? 8'h4A : 8'h6A) : 8'($urandom);
            r = $urandom_range(0, 19);
            kind = r < 3 ? 1 : (r < 5 ? 2 : 0);
            run_frame(b, $urandom_range(0, 3) != 0, kind, $urandom_range(0, 1) != 0 ? 0 : $urandom_range(1, 12));
        end

        game_alive = 1'b1;
        rx = 1'b0;
        tick(3 * DIV);
        reset_n = 1'b0;
        rx = 1'b1;
        tick(2);
        chk_reset_outputs();
        reset_n = 1'b1;
        exp_cnt = 0;
        exp_data = 8'h00;
`ifdef BT_JUMP_COOLDOWN_EN
        exp_last_pulse = -100000;
`endif
        tick(20);
        run_frame(8'h4A, 1'b1, 0, 5);
        run_frame(8'h6A, 1'b1, 0, 5);

        chk("jump_without_rx_valid", 32'(n_orphan), 32'd0);
        chk("jump_pulse_wider_than_1", 32'(n_wide), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
